tt_um_jleugeri_ttt_token_router: RTL and testbench
==================================================

Name: tt_um_jleugeri_ttt_token_router

Overview:
Receiving end of the processor core's token_startstop output. Takes start/stop events from source processors, scans a per-(source,target) weight matrix, and accumulates signed good/bad token deltas per target processor. The sequencer drains those per-target deltas into the core's new_good_tokens/new_bad_tokens inputs during the core's update phase. The block is time-multiplexed like the core: one event at a time, one target per cycle.

Parameters:
NEW_TOKEN_BITS, 4, signed width of weights, accumulators and output deltas
NUM_PROCESSORS, 10, number of source and target processors
PID_BITS, $clog2(NUM_PROCESSORS), processor index width (derived, not overridden)

Ports:
clock_fast  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high
event_valid  in  1  event offered this cycle
event_ready  out  1  router can accept an event
event_source  in  PID_BITS  processor that emitted the event
event_startstop  in  2  2'b10 token start, 2'b01 token stop
read_id  in  PID_BITS  target whose accumulated deltas are presented
read_ack  in  1  consume, i.e. clear, the accumulators of read_id
new_good_tokens  out  NEW_TOKEN_BITS  signed acc_good[read_id], combinational
new_bad_tokens  out  NEW_TOKEN_BITS  signed acc_bad[read_id], combinational
prog_we  in  1  weight write strobe
prog_source  in  PID_BITS  weight row (source)
prog_target  in  PID_BITS  weight column (target)
prog_good_weight  in  NEW_TOKEN_BITS  signed good weight
prog_bad_weight  in  NEW_TOKEN_BITS  signed bad weight
saturated  out  1  sticky flag: some accumulator has clipped since reset

Behaviour:
- Reset, synchronous, one cycle:
  - all weights and accumulators are 0;
  - FSM goes to IDLE; scan index goes to 0;
  - saturated = 0; event_ready = 1.
  - Reset overrides every other input, including a scan in progress.
- FSM states: IDLE and SCAN.
  - event_ready = 1 exactly in IDLE.
- Acceptance: the event is accepted on an edge where event_valid && event_ready.
  - A valid code (10 or 01) latches the source, latches the sign (+1 for start, -1 for stop), and moves the FSM to SCAN with idx = 0.
  - Codes 00 and 11 are consumed as no-ops: the FSM stays in IDLE and nothing changes.
- SCAN: on each edge, update target t = idx:
  - acc_good[t] = sat(acc_good[t] + sign*w_good[src][t]);
  - acc_bad[t] = sat(acc_bad[t] + sign*w_bad[src][t]);
  - then idx++.
  - After the edge with idx = NUM_PROCESSORS-1, the FSM returns to IDLE.
  - event_ready is therefore low for exactly NUM_PROCESSORS cycles after acceptance.
  - Target t is updated at the edge 1+t cycles after the acceptance edge.
- Arithmetic:
  - Sum in NEW_TOKEN_BITS+2 bits, then saturate to [-2^(NEW_TOKEN_BITS-1), 2^(NEW_TOKEN_BITS-1)-1].
  - Negating the most negative weight yields the max positive value.
  - Any clip sets saturated.
- Read:
  - Outputs always show acc[read_id] with zero latency.
  - read_ack clears both accumulators of read_id at the edge.
  - If the scan updates the same target on that edge, the result is the scan delta applied to 0. The read value is never double-counted or lost.
- Programming:
  - prog_we writes both weights at the edge, in any state.
  - A scan visit reads the weight value current in that cycle.
  - Write and visit to the same entry in the same cycle: the scan uses the old weight.
- Out-of-range ids (>= NUM_PROCESSORS):
  - events are accepted as no-ops;
  - reads return 0, and read_ack is ignored;
  - writes are ignored.

Decomposition:
- Shared package tt_um_jleugeri_ttt_pkg holds:
  - startstop code constants TOKEN_START = 2'b10 and TOKEN_STOP = 2'b01;
  - the router state enum;
  - a sat_add function parameterised by width.
- The core adopts the package's startstop constants.
- One natural sub-module: tt_um_jleugeri_ttt_weight_mem, the NUM_PROCESSORS x NUM_PROCESSORS dual-field weight RAM.
  - Write port: prog_*.
  - Read port: (src, idx), combinational.

Test Plan:
- Reset, then program w_good[2][5] = 3 and w_bad[2][7] = -2; send event (src 2, 10).
  -> event_ready low for 10 cycles; at read_id = 5, new_good = 3; at read_id = 7, new_bad = -2; all other targets read 0.
- Repeat the start event 3 times with w_good[2][5] = 3, then one stop event.
  -> acc_good[5] shows 3, then 6, then 7 with saturated = 1, then 4 after the stop.
- Assert read_ack at read_id = 5 on the exact edge the scan updates target 5 (w_good = 3, acc previously 2).
  -> the pre-edge read shows 2; after the edge acc_good[5] = 3.
- event_valid held high with code 11, then with code 00.
  -> event_ready stays high, no accumulator changes, and no SCAN is entered.
- Assert reset at scan idx 4.
  -> on the next cycle all accumulators = 0, event_ready = 1, saturated = 0, and the weights are 0.
- Write w_good[1][3] = 5 during a scan of src 1 in the cycle idx = 3, with the old weight = 1.
  -> acc_good[3] gains 1; the next start event from src 1 adds 5.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared definitions for the token processor: startstop event codes,
// router FSM states and a width-generic saturating adder.
package tt_um_jleugeri_ttt_pkg;

  localparam logic [1:0] TOKEN_START = 2'b10;
  localparam logic [1:0] TOKEN_STOP  = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } router_state_e;

  // Operands arrive sign-extended into 32 bits, so the raw sum cannot wrap
  // before it is clipped to the signed range of 'width' bits.
  function automatic int sat_add(input int a, input int b, input int width,
                                 output logic clipped);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    clipped = 1'b0;
    if (sum > hi) begin
      sat_add = hi;
      clipped = 1'b1;
    end else if (sum < lo) begin
      sat_add = lo;
      clipped = 1'b1;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_weight_mem.sv
// NUM_PROCESSORS x NUM_PROCESSORS weight RAM holding a good and a bad weight
// per (source, target); synchronous write, combinational read.
module tt_um_jleugeri_ttt_weight_mem #(
  parameter int NEW_TOKEN_BITS = 4,
  parameter int NUM_PROCESSORS = 10,
  parameter int PID_BITS       = 4
) (
  input  logic                             clock_fast,
  input  logic                             reset,
  input  logic                             we_i,
  input  logic [PID_BITS-1:0]              wr_src_i,
  input  logic [PID_BITS-1:0]              wr_tgt_i,
  input  logic signed [NEW_TOKEN_BITS-1:0] wr_good_i,
  input  logic signed [NEW_TOKEN_BITS-1:0] wr_bad_i,
  input  logic [PID_BITS-1:0]              rd_src_i,
  input  logic [PID_BITS-1:0]              rd_tgt_i,
  output logic signed [NEW_TOKEN_BITS-1:0] rd_good_o,
  output logic signed [NEW_TOKEN_BITS-1:0] rd_bad_o
);

  logic signed [NEW_TOKEN_BITS-1:0] good_q [NUM_PROCESSORS][NUM_PROCESSORS];
  logic signed [NEW_TOKEN_BITS-1:0] bad_q  [NUM_PROCESSORS][NUM_PROCESSORS];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = we_i && (int'(wr_src_i) < NUM_PROCESSORS) && (int'(wr_tgt_i) < NUM_PROCESSORS);
  assign rd_ok = (int'(rd_src_i) < NUM_PROCESSORS) && (int'(rd_tgt_i) < NUM_PROCESSORS);

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      good_q <= '{default: '0};
      bad_q  <= '{default: '0};
    end else if (wr_ok) begin
      good_q[wr_src_i][wr_tgt_i] <= wr_good_i;
      bad_q[wr_src_i][wr_tgt_i]  <= wr_bad_i;
    end
  end

  assign rd_good_o = rd_ok ? good_q[rd_src_i][rd_tgt_i] : '0;
  assign rd_bad_o  = rd_ok ? bad_q[rd_src_i][rd_tgt_i]  : '0;

endmodule

// File: rtl/tt_um_jleugeri_ttt_token_router.sv
// Token router: accepts start/stop events, scans one target per cycle through
// the weight row of the event source and accumulates saturated per-target deltas.
module tt_um_jleugeri_ttt_token_router
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter  int NEW_TOKEN_BITS = 4,
  parameter  int NUM_PROCESSORS = 10,
  localparam int PID_BITS       = $clog2(NUM_PROCESSORS)
) (
  input  logic                             clock_fast,
  input  logic                             reset,
  input  logic                             event_valid,
  output logic                             event_ready,
  input  logic [PID_BITS-1:0]              event_source,
  input  logic [1:0]                       event_startstop,
  input  logic [PID_BITS-1:0]              read_id,
  input  logic                             read_ack,
  output logic signed [NEW_TOKEN_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKEN_BITS-1:0] new_bad_tokens,
  input  logic                             prog_we,
  input  logic [PID_BITS-1:0]              prog_source,
  input  logic [PID_BITS-1:0]              prog_target,
  input  logic signed [NEW_TOKEN_BITS-1:0] prog_good_weight,
  input  logic signed [NEW_TOKEN_BITS-1:0] prog_bad_weight,
  output logic                             saturated
);

  typedef logic signed [NEW_TOKEN_BITS-1:0] tok_t;

  localparam logic [PID_BITS-1:0] LAST_IDX = PID_BITS'(NUM_PROCESSORS - 1);

  // Handshake: an event transfers on a rising edge where event_valid and
  // event_ready are both high; event_ready is high only while IDLE.
  router_state_e       state_q, state_d;
  logic [PID_BITS-1:0] idx_q, idx_d;
  logic [PID_BITS-1:0] src_q, src_d;
  logic                neg_q, neg_d;
  logic                sat_q, sat_d;
  tok_t                acc_good_q [NUM_PROCESSORS];
  tok_t                acc_good_d [NUM_PROCESSORS];
  tok_t                acc_bad_q  [NUM_PROCESSORS];
  tok_t                acc_bad_d  [NUM_PROCESSORS];

  tok_t w_good;
  tok_t w_bad;
  logic read_ok;
  logic src_ok;
  logic code_ok;

  assign read_ok = int'(read_id) < NUM_PROCESSORS;
  assign src_ok  = int'(event_source) < NUM_PROCESSORS;
  assign code_ok = (event_startstop == TOKEN_START) || (event_startstop == TOKEN_STOP);

  tt_um_jleugeri_ttt_weight_mem #(
    .NEW_TOKEN_BITS(NEW_TOKEN_BITS),
    .NUM_PROCESSORS(NUM_PROCESSORS),
    .PID_BITS      (PID_BITS)
  ) u_weight_mem (
    .clock_fast(clock_fast),
    .reset     (reset),
    .we_i      (prog_we),
    .wr_src_i  (prog_source),
    .wr_tgt_i  (prog_target),
    .wr_good_i (prog_good_weight),
    .wr_bad_i  (prog_bad_weight),
    .rd_src_i  (src_q),
    .rd_tgt_i  (idx_q),
    .rd_good_o (w_good),
    .rd_bad_o  (w_bad)
  );

  always_comb begin
    int   sum_good;
    int   sum_bad;
    int   delta_good;
    int   delta_bad;
    logic clip_good;
    logic clip_bad;
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    neg_d      = neg_q;
    sat_d      = sat_q;
    acc_good_d = acc_good_q;
    acc_bad_d  = acc_bad_q;
    sum_good   = 0;
    sum_bad    = 0;
    delta_good = 0;
    delta_bad  = 0;
    clip_good  = 1'b0;
    clip_bad   = 1'b0;

    // Clearing first lets a coincident scan visit apply its delta to zero.
    if (read_ack && read_ok) begin
      acc_good_d[read_id] = '0;
      acc_bad_d[read_id]  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (event_valid && src_ok && code_ok) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          src_d   = event_source;
          neg_d   = (event_startstop == TOKEN_STOP);
        end
      end
      ST_SCAN: begin
        delta_good = neg_q ? -int'(w_good) : int'(w_good);
        delta_bad  = neg_q ? -int'(w_bad)  : int'(w_bad);
        sum_good = sat_add(int'(acc_good_d[idx_q]), delta_good, NEW_TOKEN_BITS, clip_good);
        sum_bad  = sat_add(int'(acc_bad_d[idx_q]),  delta_bad,  NEW_TOKEN_BITS, clip_bad);
        acc_good_d[idx_q] = sum_good[NEW_TOKEN_BITS-1:0];
        acc_bad_d[idx_q]  = sum_bad[NEW_TOKEN_BITS-1:0];
        if (clip_good || clip_bad) begin
          sat_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      src_q      <= '0;
      neg_q      <= 1'b0;
      sat_q      <= 1'b0;
      acc_good_q <= '{default: '0};
      acc_bad_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      neg_q      <= neg_d;
      sat_q      <= sat_d;
      acc_good_q <= acc_good_d;
      acc_bad_q  <= acc_bad_d;
    end
  end

  assign event_ready     = (state_q == ST_IDLE);
  assign saturated       = sat_q;
  assign new_good_tokens = read_ok ? acc_good_q[read_id] : '0;
  assign new_bad_tokens  = read_ok ? acc_bad_q[read_id]  : '0;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_router.sv
// Bench for the token router: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against an event-level reference model.
module tb_tt_um_jleugeri_ttt_token_router;

  localparam int NTB = 4;
  localparam int N   = 10;
  localparam int PB  = 4;
  localparam int MAXV = (1 << (NTB - 1)) - 1;
  localparam int MINV = -(1 << (NTB - 1));

  logic                  clock_fast = 1'b0;
  logic                  reset = 1'b1;
  logic                  event_valid = 1'b0;
  logic                  event_ready;
  logic [PB-1:0]         event_source = '0;
  logic [1:0]            event_startstop = '0;
  logic [PB-1:0]         read_id = '0;
  logic                  read_ack = 1'b0;
  logic signed [NTB-1:0] new_good_tokens;
  logic signed [NTB-1:0] new_bad_tokens;
  logic                  prog_we = 1'b0;
  logic [PB-1:0]         prog_source = '0;
  logic [PB-1:0]         prog_target = '0;
  logic signed [NTB-1:0] prog_good_weight = '0;
  logic signed [NTB-1:0] prog_bad_weight = '0;
  logic                  saturated;

  always #5 clock_fast = ~clock_fast;

  tt_um_jleugeri_ttt_token_router #(
    .NEW_TOKEN_BITS(NTB),
    .NUM_PROCESSORS(N)
  ) dut (
    .clock_fast      (clock_fast),
    .reset           (reset),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_source    (event_source),
    .event_startstop (event_startstop),
    .read_id         (read_id),
    .read_ack        (read_ack),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .prog_we         (prog_we),
    .prog_source     (prog_source),
    .prog_target     (prog_target),
    .prog_good_weight(prog_good_weight),
    .prog_bad_weight (prog_bad_weight),
    .saturated       (saturated)
  );

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // Reference model: weights, accumulators, and the event being scanned
  // expressed as "cycles left"; target = N - cycles_left.
  int m_wg [N][N];
  int m_wb [N][N];
  int m_ag [N];
  int m_ab [N];
  bit m_sat;
  int m_left;
  int m_src;
  int m_sign;
  int m_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    if (v > MAXV) begin
      m_sat = 1'b1;
      return MAXV;
    end
    if (v < MINV) begin
      m_sat = 1'b1;
      return MINV;
    end
    return v;
  endfunction

  always @(posedge clock_fast) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_ag[i] = 0;
        m_ab[i] = 0;
        for (int j = 0; j < N; j++) begin
          m_wg[i][j] = 0;
          m_wb[i][j] = 0;
        end
      end
      m_left = 0;
      m_sat = 1'b0;
      m_src = 0;
      m_sign = 0;
    end else begin
      if (read_ack && read_id < N) begin
        m_ag[read_id] = 0;
        m_ab[read_id] = 0;
      end
      if (m_left > 0) begin
        m_t = N - m_left;
        m_ag[m_t] = clip(m_ag[m_t] + m_sign * m_wg[m_src][m_t]);
        m_ab[m_t] = clip(m_ab[m_t] + m_sign * m_wb[m_src][m_t]);
        m_left--;
      end else if (event_valid && event_source < N &&
                   (event_startstop == 2'b10 || event_startstop == 2'b01)) begin
        m_left = N;
        m_src = int'(event_source);
        m_sign = (event_startstop == 2'b10) ? 1 : -1;
      end
      if (prog_we && prog_source < N && prog_target < N) begin
        m_wg[prog_source][prog_target] = int'(prog_good_weight);
        m_wb[prog_source][prog_target] = int'(prog_bad_weight);
      end
    end
  end

  always @(negedge clock_fast) begin
    if (checking) begin
      chk("ready", int'(event_ready), (m_left == 0) ? 1 : 0);
      chk("saturated", int'(saturated), int'(m_sat));
      chk("good", int'(new_good_tokens), (read_id < N) ? m_ag[read_id] : 0);
      chk("bad", int'(new_bad_tokens), (read_id < N) ? m_ab[read_id] : 0);
    end
  end

  task automatic tick();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic prog(input int s, input int t, input int g, input int b);
    prog_we = 1'b1;
    prog_source = PB'(s);
    prog_target = PB'(t);
    prog_good_weight = NTB'(g);
    prog_bad_weight = NTB'(b);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wait_scan(output int n);
    n = 0;
    while (!event_ready && n < 40) begin
      tick();
      n++;
    end
    if (!event_ready) chk("scan_timeout", 0, 1);
  endtask

  task automatic send(input int s, input logic [1:0] code);
    int n;
    wait_scan(n);
    event_valid = 1'b1;
    event_source = PB'(s);
    event_startstop = code;
    tick();
    event_valid = 1'b0;
  endtask

  task automatic lit_read(input string name, input int id, input int g, input int b);
    read_id = PB'(id);
    #1;
    chk({name, "_good"}, int'(new_good_tokens), g);
    chk({name, "_bad"}, int'(new_bad_tokens), b);
    tick();
  endtask

  initial begin
    int n;
    int exp_seq[3];
    exp_seq = '{3, 6, 7};

    repeat (2) tick();
    checking = 1'b1;
    reset = 1'b0;
    chk("rst_ready", int'(event_ready), 1);
    chk("rst_sat", int'(saturated), 0);
    chk("rst_good", int'(new_good_tokens), 0);

    // Single start event with two programmed weights
    prog(2, 5, 3, 0);
    prog(2, 7, 0, -2);
    send(2, 2'b10);
    wait_scan(n);
    chk("busy_cycles", n, 10);
    for (int i = 0; i < N; i++) begin
      lit_read("single", i, (i == 5) ? 3 : 0, (i == 7) ? -2 : 0);
    end
    lit_read("oor_read", 12, 0, 0);

    // Accumulate to saturation, then stop
    read_ack = 1'b1;
    read_id = 4'd5;
    tick();
    read_id = 4'd7;
    tick();
    read_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(2, 2'b10);
      wait_scan(n);
      chk("acc_sat_flag", int'(saturated), (k == 2) ? 1 : 0);
      lit_read("acc_seq", 5, exp_seq[k], 0);
    end
    send(2, 2'b01);
    wait_scan(n);
    lit_read("after_stop5", 5, 4, 0);
    lit_read("after_stop7", 7, 0, -4);

    // read_ack coinciding with the scan visit of the same target
    read_id = 4'd5;
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    prog(2, 5, 1, 0);
    send(2, 2'b10);
    wait_scan(n);
    send(2, 2'b10);
    wait_scan(n);
    lit_read("pre_ack", 5, 2, 0);
    prog(2, 5, 3, 0);
    send(2, 2'b10);
    repeat (5) tick();
    read_id = 4'd5;
    read_ack = 1'b1;
    #1;
    chk("ack_pre_edge", int'(new_good_tokens), 2);
    tick();
    read_ack = 1'b0;
    #1;
    chk("ack_post_edge", int'(new_good_tokens), 3);
    wait_scan(n);
    chk("ack_rest_cycles", n, 4);

    // Invalid codes and out-of-range source are consumed as no-ops
    event_valid = 1'b1;
    event_source = 4'd2;
    event_startstop = 2'b11;
    repeat (4) begin tick(); chk("noop11_ready", int'(event_ready), 1); end
    event_startstop = 2'b00;
    repeat (4) begin tick(); chk("noop00_ready", int'(event_ready), 1); end
    event_source = 4'd12;
    event_startstop = 2'b10;
    repeat (4) begin tick(); chk("noop_oor_ready", int'(event_ready), 1); end
    event_valid = 1'b0;
    lit_read("noop_acc", 5, 3, 0);

    // Reset in the middle of a scan
    send(2, 2'b10);
    repeat (4) tick();
    chk("pre_reset_sat", int'(saturated), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("post_reset_ready", int'(event_ready), 1);
    chk("post_reset_sat", int'(saturated), 0);
    for (int i = 0; i < N; i++) lit_read("post_reset", i, 0, 0);
    send(2, 2'b10);
    wait_scan(n);
    lit_read("zero_w5", 5, 0, 0);
    lit_read("zero_w7", 7, 0, 0);

    // Weight write on the same edge the scan visits that entry
    prog(1, 3, 1, 0);
    send(1, 2'b10);
    repeat (3) tick();
    prog(1, 3, 5, 0);
    wait_scan(n);
    lit_read("old_weight", 3, 1, 0);
    send(1, 2'b10);
    wait_scan(n);
    lit_read("new_weight", 3, 6, 0);

    // Random traffic against the model
    repeat (600) begin
      event_valid = ($urandom_range(0, 1) == 1);
      event_source = PB'($urandom_range(0, 11));
      event_startstop = 2'($urandom_range(0, 3));
      read_id = PB'($urandom_range(0, 11));
      read_ack = ($urandom_range(0, 4) == 0);
      prog_we = ($urandom_range(0, 3) == 0);
      prog_source = PB'($urandom_range(0, 11));
      prog_target = PB'($urandom_range(0, 11));
      prog_good_weight = NTB'($urandom_range(0, 15));
      prog_bad_weight = NTB'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    event_valid = 1'b0;
    read_ack = 1'b0;
    prog_we = 1'b0;
    reset = 1'b0;
    repeat (12) tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
